// File: rtl/display_scan_ctrl.sv
// HUB75 scan controller: row x bit-plane x column read sequencing, BCM on-time and
// frame-aligned buffer swap. Define DISPLAY_SCAN_BRIGHTNESS_EN to add a global brightness input.
module display_scan_ctrl #(
    parameter int ROWS       = 8,
    parameter int COLUMNS    = 32,
    parameter int WIDTH      = 24,
    parameter int DEPTH      = 8,
    parameter int BASE_TICKS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       swap_req,
    output logic                       swap_ack,
    output logic                       flip,
    output logic [$clog2(ROWS)-1:0]    rrow,
    output logic [$clog2(COLUMNS)-1:0] rcol,
    input  logic [WIDTH-1:0]           rdata,
    output logic                       pnl_r,
    output logic                       pnl_g,
    output logic                       pnl_b,
    output logic                       pnl_clk,
    output logic                       pnl_lat,
    output logic                       pnl_oe,
    output logic [$clog2(ROWS)-1:0]    pnl_addr,
    output logic                       frame_start
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    ,
    input  logic [4:0]                 brightness
`endif
);

    localparam int ROW_W     = $clog2(ROWS);
    localparam int COL_W     = $clog2(COLUMNS);
    localparam int PL_W      = $clog2(DEPTH);
    localparam int SHIFT_LEN = 2 * COLUMNS + 2;
    localparam int MAX_SHOW  = BASE_TICKS << (DEPTH - 1);
    localparam int CNT_W     = $clog2((SHIFT_LEN > MAX_SHOW) ? SHIFT_LEN : MAX_SHOW) + 1;

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_END   = CNT_W'(2 * COLUMNS);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [PL_W-1:0]  PL_LAST    = PL_W'(DEPTH - 1);

    typedef enum logic [1:0] {ST_SHIFT, ST_LATCH, ST_SHOW, ST_DEAD} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [PL_W-1:0]  plane_q, plane_d;
    logic             flip_q, flip_d;
    logic             pending_q, pending_d;
    logic             ack_q, ack_d;
    logic [ROW_W-1:0] addr_q, addr_d;
    logic             r_q, r_d, g_q, g_d, b_q, b_d;
    logic             clk_q, clk_d;

    logic [DEPTH-1:0] r_ch, g_ch, b_ch;
    logic [CNT_W-1:0] show_last;
    logic             frame_end;

    assign r_ch      = rdata[2*DEPTH +: DEPTH];
    assign g_ch      = rdata[DEPTH   +: DEPTH];
    assign b_ch      = rdata[0       +: DEPTH];
    assign show_last = (CNT_W'(BASE_TICKS) << plane_q) - CNT_W'(1);
    assign frame_end = (state_q == ST_DEAD) && (row_q == ROW_LAST) && (plane_q == PL_LAST);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        plane_d   = plane_q;
        flip_d    = flip_q;
        pending_d = pending_q | swap_req;
        ack_d     = 1'b0;
        addr_d    = addr_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        clk_d     = 1'b0;

        case (state_q)
            ST_SHIFT: begin
                // Even counts past the first read raise the shift clock; odd counts capture the pixel.
                clk_d = !cnt_q[0] && (cnt_q >= CNT_W'(2)) && (cnt_q <= DATA_END);
                if (cnt_q[0] && (cnt_q < DATA_END)) begin
                    r_d = r_ch[plane_q];
                    g_d = g_ch[plane_q];
                    b_d = b_ch[plane_q];
                end
                if (cnt_q == SHIFT_LAST) begin
                    state_d = ST_LATCH;
                    cnt_d   = '0;
                    addr_d  = row_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LATCH: begin
                state_d = ST_SHOW;
                cnt_d   = '0;
            end
            ST_SHOW: begin
                if (cnt_q == show_last) begin
                    state_d = ST_DEAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DEAD: begin
                state_d = ST_SHIFT;
                cnt_d   = '0;
                if (plane_q == PL_LAST) begin
                    plane_d = '0;
                    row_d   = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
                end else begin
                    plane_d = plane_q + PL_W'(1);
                end
                if (frame_end && (pending_q || swap_req)) begin
                    flip_d    = !flip_q;
                    ack_d     = 1'b1;
                    pending_d = 1'b0;
                end
            end
            default: state_d = ST_SHIFT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; the reset is synchronous, so rst
    // is only the first branch and never appears in the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_SHIFT;
            cnt_q     <= '0;
            row_q     <= '0;
            plane_q   <= '0;
            flip_q    <= 1'b0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            addr_q    <= '0;
            r_q       <= 1'b0;
            g_q       <= 1'b0;
            b_q       <= 1'b0;
            clk_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            plane_q   <= plane_d;
            flip_q    <= flip_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            addr_q    <= addr_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            clk_q     <= clk_d;
        end
    end

    assign swap_ack    = ack_q;
    assign flip        = flip_q;
    assign rrow        = row_q;
    assign rcol        = (state_q == ST_SHIFT) ? cnt_q[COL_W:1] : '0;
    assign pnl_r       = r_q;
    assign pnl_g       = g_q;
    assign pnl_b       = b_q;
    assign pnl_clk     = clk_q;
    assign pnl_lat     = (state_q == ST_LATCH);
    assign pnl_addr    = addr_q;
    // Gated by rst so the pulse stays low while reset is held and fires on the first free cycle.
    assign frame_start = !rst && (state_q == ST_SHIFT) && (cnt_q == '0) &&
                         (row_q == '0) && (plane_q == '0);

`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    logic [4:0] bright_sat;
    assign bright_sat = (brightness > 5'd16) ? 5'd16 : brightness;
    assign pnl_oe     = !((state_q == ST_SHOW) && ({1'b0, cnt_q[3:0]} < bright_sat));
`else
    assign pnl_oe     = (state_q != ST_SHOW);
`endif

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: frame-position reference model checked every
// cycle, plus literal timing checks, swap handling and mid-frame reset.
`timescale 1ns/1ps
module tb_display_scan_ctrl;

    localparam int ROWS       = 8;
    localparam int COLUMNS    = 32;
    localparam int WIDTH      = 24;
    localparam int DEPTH      = 8;
    localparam int BASE_TICKS = 2;
    localparam int SHIFT_LEN  = 2 * COLUMNS + 2;
    localparam int ROW_LEN    = DEPTH * (2 * COLUMNS + 4) + BASE_TICKS * ((1 << DEPTH) - 1);
    localparam int FRAME_LEN  = ROWS * ROW_LEN;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        swap_req = 1'b0;
    logic        swap_ack, flip;
    logic [2:0]  rrow;
    logic [4:0]  rcol;
    logic [23:0] rdata;
    logic        pnl_r, pnl_g, pnl_b, pnl_clk, pnl_lat, pnl_oe;
    logic [2:0]  pnl_addr;
    logic        frame_start;
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    logic [4:0]  brightness = 5'd16;
`endif

    display_scan_ctrl #(
        .ROWS(ROWS), .COLUMNS(COLUMNS), .WIDTH(WIDTH), .DEPTH(DEPTH), .BASE_TICKS(BASE_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .swap_req(swap_req), .swap_ack(swap_ack), .flip(flip),
        .rrow(rrow), .rcol(rcol), .rdata(rdata),
        .pnl_r(pnl_r), .pnl_g(pnl_g), .pnl_b(pnl_b), .pnl_clk(pnl_clk), .pnl_lat(pnl_lat),
        .pnl_oe(pnl_oe), .pnl_addr(pnl_addr), .frame_start(frame_start)
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
        , .brightness(brightness)
`endif
    );

    always #5 clk = ~clk;

    // Double-buffered display memory, one-cycle read latency.
    logic [WIDTH-1:0] mem [2][ROWS][COLUMNS];
    always @(posedge clk) rdata <= mem[flip][rrow][rcol];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: position within the frame decoded arithmetically each cycle.
    int         m_t = 0;
    bit         m_valid = 1'b0, m_flip = 1'b0, m_pend = 1'b0, m_ack = 1'b0;
    int         m_addr = 0;
    logic [2:0] m_rgb = 3'b000;

    initial begin
        int row, plane, o, show_len;
        bit in_shift, in_latch, in_show;
        logic [WIDTH-1:0] px;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                row   = m_t / ROW_LEN;
                o     = m_t % ROW_LEN;
                plane = 0;
                while (o >= 2 * COLUMNS + 4 + (BASE_TICKS << plane)) begin
                    o = o - (2 * COLUMNS + 4 + (BASE_TICKS << plane));
                    plane++;
                end
                show_len = BASE_TICKS << plane;
                in_shift = (o < SHIFT_LEN);
                in_latch = (o == SHIFT_LEN);
                in_show  = (o > SHIFT_LEN) && (o <= SHIFT_LEN + show_len);
                if (in_latch) m_addr = row;
                if (in_shift && o >= 2 && (o % 2) == 0) begin
                    px    = mem[m_flip][row][(o - 2) / 2];
                    m_rgb = {px[16 + plane], px[8 + plane], px[plane]};
                end
                check("pnl_oe", pnl_oe, !in_show);
                check("pnl_lat", pnl_lat, in_latch);
                check("pnl_clk", pnl_clk, in_shift && o >= 3 && (o % 2) == 1);
                check("pnl_addr", pnl_addr, m_addr);
                check("pnl_rgb", {pnl_r, pnl_g, pnl_b}, m_rgb);
                check("flip", flip, m_flip);
                check("swap_ack", swap_ack, m_ack);
                check("frame_start", frame_start, (m_t == 0) && !rst);
                if (in_shift) check("rrow", rrow, row);
                if (in_shift && o < 2 * COLUMNS) check("rcol", rcol, o / 2);
            end
            if (rst) begin
                m_valid = 1'b1;
                m_t     = 0;
                m_flip  = 1'b0;
                m_pend  = 1'b0;
                m_ack   = 1'b0;
                m_addr  = 0;
                m_rgb   = 3'b000;
            end else if (m_valid) begin
                m_ack = 1'b0;
                if (swap_req) m_pend = 1'b1;
                if (m_t == FRAME_LEN - 1) begin
                    if (m_pend) begin
                        m_flip = !m_flip;
                        m_ack  = 1'b1;
                        m_pend = 1'b0;
                    end
                    m_t = 0;
                end else begin
                    m_t++;
                end
            end
        end
    end

    task automatic pulse_swap();
        @(posedge clk); #1 swap_req = 1'b1;
        @(posedge clk); #1 swap_req = 1'b0;
    endtask

    // Returns at the negedge of the next frame_start cycle, counting swap_ack pulses on the way.
    task automatic wait_frame(output bit found, output int acks);
        found = 1'b0;
        acks  = 0;
        for (int i = 0; i < FRAME_LEN + 16 && !found; i++) begin
            @(negedge clk);
            if (swap_ack) acks++;
            if (frame_start) found = 1'b1;
        end
        check("frame_start_seen", found, 1);
    endtask

    initial begin
        int  edges, first_low, next_fs, lat_cnt, run, run_idx, acks;
        bit  prev_clk, found;

        for (int f = 0; f < 2; f++)
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLUMNS; c++)
                    mem[f][r][c] = WIDTH'($urandom);
        for (int c = 0; c < COLUMNS; c++)
            mem[0][0][c] = (c % 2 == 0) ? 24'h800001 : 24'h000000;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // First frame after reset: literal timing of the opening planes and frame period.
        edges = 0; first_low = -1; next_fs = -1; lat_cnt = 0; run = 0; run_idx = 0; prev_clk = 1'b0;
        for (int n = 0; n <= FRAME_LEN; n++) begin
            @(negedge clk);
            if (n == 0) check("fs_at_release", frame_start, 1);
            if (n > 0 && frame_start && next_fs < 0) next_fs = n;
            if (!pnl_oe && first_low < 0) first_low = n;
            if (n < SHIFT_LEN && pnl_clk && !prev_clk) begin
                check("p0_edge_r", pnl_r, 0);
                check("p0_edge_b", pnl_b, (edges % 2 == 0));
                edges++;
            end
            if (n < ROW_LEN) begin
                if (pnl_lat) lat_cnt++;
                if (!pnl_oe) begin
                    run++;
                end else if (run > 0) begin
                    check("show_len", run, 2 << run_idx);
                    run_idx++;
                    run = 0;
                end
            end
            prev_clk = pnl_clk;
        end
        check("first_oe_low", first_low, 67);
        check("frame_period", next_fs, 8432);
        check("p0_edges", edges, 32);
        check("row0_latches", lat_cnt, 8);
        check("row0_show_runs", run_idx, 8);

        // Swap pending, then reset in the middle of a long SHOW.
        pulse_swap();
        repeat (3000) @(posedge clk);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (!pnl_oe) found = 1'b1;
        end
        check("oe_low_seen", found, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_oe", pnl_oe, 1);
        check("rst_flip", flip, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_fs", frame_start, 1);
        check("rst_no_ack", swap_ack, 0);

        // Two requests in one frame give a single swap at the next frame start.
        repeat (2000) @(posedge clk);
        pulse_swap();
        repeat (500) @(posedge clk);
        pulse_swap();
        wait_frame(found, acks);
        check("swap_ack_at_fs", swap_ack, 1);
        check("flip_after_swap", flip, 1);
        check("ack_pulses", acks, 1);

        // Request landing on the frame-ending DEAD cycle is honoured immediately.
        repeat (FRAME_LEN - 1) @(posedge clk);
        #1 swap_req = 1'b1;
        @(posedge clk); #1 swap_req = 1'b0;
        @(negedge clk);
        check("edge_swap_fs", frame_start, 1);
        check("edge_swap_ack", swap_ack, 1);
        check("edge_swap_flip", flip, 0);

        // Random sparse requests across more than a full frame.
        for (int i = 0; i < FRAME_LEN + 200; i++) begin
            @(posedge clk);
            #1 swap_req = ($urandom_range(0, 999) == 0);
        end
        @(posedge clk); #1 swap_req = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
